// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-clock data memory with per-byte write enables,
// a 1- or 2-stage registered read pipeline with a valid strobe, and a
// clear sequencer that zeroes every word after reset or on clearRequest.
// Optional feature macro: DATAMEM_BYPASS_EN (write-first merge on a
// same-cycle, same-address read/write). Without it, reads are read-first.
module data_memory_ctrl #(
    parameter int DATA_WIDTH         = 32,
    parameter int BYTE_WIDTH         = 8,
    parameter int DATAMEM_ADDR_WIDTH = 11,
    parameter int RAM_DEPTH          = 1 << DATAMEM_ADDR_WIDTH,
    parameter int READ_LATENCY       = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 clearRequest,
    output logic                                 ready,
    input  logic                                 writeEnable,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     byteEnable,
    input  logic [DATAMEM_ADDR_WIDTH-1:0]        writeAddr,
    input  logic [DATA_WIDTH-1:0]                writeData,
    input  logic                                 readEnable,
    input  logic [DATAMEM_ADDR_WIDTH-1:0]        readAddr,
    output logic [DATA_WIDTH-1:0]                readData,
    output logic                                 readValid
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t                          state;
    state_t                          nextState;
    logic [DATAMEM_ADDR_WIDTH-1:0]   sweepCount;
    logic                            sweepActive;
    logic                            sweepLast;
    logic                            writeAccept;
    logic                            readAccept;
    logic [DATA_WIDTH-1:0]           readWord;
    logic [DATA_WIDTH-1:0]           mem [RAM_DEPTH];

    logic [DATA_WIDTH-1:0]           rdData_p0;
    logic                            vld_p0;

    assign sweepLast   = (sweepCount == DATAMEM_ADDR_WIDTH'(RAM_DEPTH - 1));
    assign writeAccept = ready & writeEnable;
    assign readAccept  = ready & readEnable;

    // State register; reset always lands in INIT so the array gets zeroed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and outputs: INIT and CLEAR share the same sweep, RUN serves traffic.
    always_comb begin
        nextState   = state;
        ready       = 1'b0;
        sweepActive = 1'b0;
        case (state)
            INIT: begin
                sweepActive = 1'b1;
                if (sweepLast) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
                if (clearRequest) begin
                    nextState = CLEAR;
                end
            end
            CLEAR: begin
                // clearRequest is deliberately not looked at here, so a
                // second request neither restarts nor extends the sweep.
                sweepActive = 1'b1;
                if (sweepLast) begin
                    nextState = RUN;
                end
            end
            default: begin
                nextState = INIT;
            end
        endcase
    end

    // Sweep address counter; wraps back to 0 at the last word so the next sweep starts clean.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sweepCount <= '0;
        end else if (sweepActive) begin
            if (sweepLast) begin
                sweepCount <= '0;
            end else begin
                sweepCount <= sweepCount + 1'b1;
            end
        end else begin
            sweepCount <= '0;
        end
    end

    // Array write port: the sweep owns the port while active; user writes need ready.
    always_ff @(posedge clock) begin
        if (sweepActive) begin
            mem[sweepCount] <= '0;
        end else if (writeAccept) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (byteEnable[b]) begin
                    mem[writeAddr][b*BYTE_WIDTH +: BYTE_WIDTH] <= writeData[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Word presented to the read pipeline, with optional write-first byte merge.
    always_comb begin
        readWord = mem[readAddr];
`ifdef DATAMEM_BYPASS_EN
        if (writeAccept && (writeAddr == readAddr)) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (byteEnable[b]) begin
                    readWord[b*BYTE_WIDTH +: BYTE_WIDTH] = writeData[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
`endif
    end

    // ---- stage p0: array read register; data only moves on an accepted read ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p0    <= 1'b0;
            rdData_p0 <= '0;
        end else begin
            vld_p0 <= readAccept;
            if (readAccept) begin
                rdData_p0 <= readWord;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : gen_lat2
            logic [DATA_WIDTH-1:0] rdData_p1;
            logic                  vld_p1;

            // ---- stage p1: extra output register, holds until the next valid read ----
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    vld_p1    <= 1'b0;
                    rdData_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        rdData_p1 <= rdData_p0;
                    end
                end
            end

            assign readData  = rdData_p1;
            assign readValid = vld_p1;
        end else begin : gen_lat1
            assign readData  = rdData_p0;
            assign readValid = vld_p0;
        end
    endgenerate

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a default instance (2048 words,
// READ_LATENCY=1) and a small instance (16 words, READ_LATENCY=2).
module tb_data_memory_ctrl;

    logic        clock;
    logic        reset;

    // default instance signals
    logic        clearRequest;
    logic        ready;
    logic        writeEnable;
    logic [3:0]  byteEnable;
    logic [10:0] writeAddr;
    logic [31:0] writeData;
    logic        readEnable;
    logic [10:0] readAddr;
    logic [31:0] readData;
    logic        readValid;

    // small instance signals
    logic        sClear;
    logic        sReady;
    logic        sWe;
    logic [3:0]  sBe;
    logic [3:0]  sWaddr;
    logic [31:0] sWdata;
    logic        sRe;
    logic [3:0]  sRaddr;
    logic [31:0] sRdata;
    logic        sValid;

    int checks;
    int errors;
    int cnt;

    data_memory_ctrl dut (
        .clock(clock), .reset(reset), .clearRequest(clearRequest), .ready(ready),
        .writeEnable(writeEnable), .byteEnable(byteEnable), .writeAddr(writeAddr),
        .writeData(writeData), .readEnable(readEnable), .readAddr(readAddr),
        .readData(readData), .readValid(readValid)
    );

    data_memory_ctrl #(.DATAMEM_ADDR_WIDTH(4), .READ_LATENCY(2)) dutSmall (
        .clock(clock), .reset(reset), .clearRequest(sClear), .ready(sReady),
        .writeEnable(sWe), .byteEnable(sBe), .writeAddr(sWaddr),
        .writeData(sWdata), .readEnable(sRe), .readAddr(sRaddr),
        .readData(sRdata), .readValid(sValid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        clearRequest = 1'b0; writeEnable = 1'b0; byteEnable = 4'h0;
        writeAddr = '0; writeData = '0; readEnable = 1'b0; readAddr = '0;
        sClear = 1'b0; sWe = 1'b0; sBe = 4'h0; sWaddr = '0; sWdata = '0;
        sRe = 1'b0; sRaddr = '0;

        // reset state
        tick(); tick();
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_valid", 32'(readValid), 32'd0);
        chk("reset_data", readData, 32'h0);

        // 1: initial sweep length, then read of the last word
        reset = 1'b0;
        chk("init_ready_low", 32'(ready), 32'd0);
        cnt = 0;
        while (!ready && cnt < 5000) begin
            tick();
            cnt++;
        end
        chk("init_sweep_len", 32'(cnt), 32'd2048);
        readEnable = 1'b1; readAddr = 11'h7FF;
        tick();
        readEnable = 1'b0;
        chk("rd7ff_valid", 32'(readValid), 32'd1);
        chk("rd7ff_data", readData, 32'h0);
        tick();
        chk("rd7ff_pulse", 32'(readValid), 32'd0);

        // 2: byte-masked write merge and a byteEnable=0 no-op write
        writeEnable = 1'b1; writeAddr = 11'h010; writeData = 32'hDEADBEEF; byteEnable = 4'b1111;
        tick();
        writeData = 32'h000000AA; byteEnable = 4'b0001;
        tick();
        writeData = 32'hFFFFFFFF; byteEnable = 4'b0000;
        tick();
        writeEnable = 1'b0;
        readEnable = 1'b1; readAddr = 11'h010;
        tick();
        readEnable = 1'b0;
        chk("bytemask_valid", 32'(readValid), 32'd1);
        chk("bytemask_data", readData, 32'hDEADBEAA);

        // 3: same-cycle same-address write and read
        writeEnable = 1'b1; writeAddr = 11'h020; writeData = 32'h12345678; byteEnable = 4'b1111;
        readEnable = 1'b1; readAddr = 11'h020;
        tick();
        writeEnable = 1'b0;
`ifdef DATAMEM_BYPASS_EN
        chk("collide_data", readData, 32'h12345678);
`else
        chk("collide_data", readData, 32'h00000000);
`endif
        tick();
        readEnable = 1'b0;
        chk("collide_next", readData, 32'h12345678);

        // 4: latency-2 instance, back-to-back reads
        chk("small_ready", 32'(sReady), 32'd1);
        sWe = 1'b1; sBe = 4'b1111;
        sWaddr = 4'h1; sWdata = 32'h000000A1; tick();
        sWaddr = 4'h2; sWdata = 32'h000000B2; tick();
        sWaddr = 4'h3; sWdata = 32'h000000C3; tick();
        sWe = 1'b0;
        sRe = 1'b1; sRaddr = 4'h1;
        tick();
        chk("lat2_e1_valid", 32'(sValid), 32'd0);
        sRaddr = 4'h2;
        tick();
        chk("lat2_e2_valid", 32'(sValid), 32'd1);
        chk("lat2_e2_data", sRdata, 32'h000000A1);
        sRaddr = 4'h3;
        tick();
        sRe = 1'b0;
        chk("lat2_e3_valid", 32'(sValid), 32'd1);
        chk("lat2_e3_data", sRdata, 32'h000000B2);
        tick();
        chk("lat2_e4_valid", 32'(sValid), 32'd1);
        chk("lat2_e4_data", sRdata, 32'h000000C3);
        tick();
        chk("lat2_e5_valid", 32'(sValid), 32'd0);
        chk("lat2_e5_hold", sRdata, 32'h000000C3);

        // 5: clear sweep; read before clear drains, writes during sweep dropped
        writeEnable = 1'b1; writeAddr = 11'h005; writeData = 32'hCAFEF00D; byteEnable = 4'b1111;
        tick();
        writeEnable = 1'b0;
        clearRequest = 1'b1; readEnable = 1'b1; readAddr = 11'h010;
        tick();
        clearRequest = 1'b0;
        chk("clear_ready_low", 32'(ready), 32'd0);
        chk("clear_drain_valid", 32'(readValid), 32'd1);
        chk("clear_drain_data", readData, 32'hDEADBEAA);
        readAddr = 11'h005;
        cnt = 0;
        while (!ready && cnt < 5000) begin
            tick();
            cnt++;
            if (cnt == 1) begin
                readEnable = 1'b0;
                chk("sweep_read_dropped", 32'(readValid), 32'd0);
            end
            if (cnt == 5) clearRequest = 1'b1;
            if (cnt == 6) clearRequest = 1'b0;
            if (cnt == 100) begin
                writeEnable = 1'b1; writeAddr = 11'h005; writeData = 32'h11111111;
            end
            if (cnt == 101) writeEnable = 1'b0;
        end
        chk("clear_sweep_len", 32'(cnt), 32'd2048);
        readEnable = 1'b1; readAddr = 11'h005;
        tick();
        readEnable = 1'b0;
        chk("after_clear_valid", 32'(readValid), 32'd1);
        chk("after_clear_data", readData, 32'h00000000);

        // 6: reset in the middle of a clear sweep
        writeEnable = 1'b1; writeAddr = 11'h030; writeData = 32'hABCD1234; byteEnable = 4'b1111;
        tick();
        writeEnable = 1'b0;
        readEnable = 1'b1; readAddr = 11'h030;
        tick();
        readEnable = 1'b0;
        clearRequest = 1'b1;
        tick();
        clearRequest = 1'b0;
        for (int i = 0; i < 32'h200; i++) tick();
        chk("midsweep_hold", readData, 32'hABCD1234);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_valid", 32'(readValid), 32'd0);
        chk("midreset_data", readData, 32'h0);
        chk("midreset_ready", 32'(ready), 32'd0);
        tick();
        reset = 1'b0;
        cnt = 0;
        while (!ready && cnt < 5000) begin
            tick();
            cnt++;
        end
        chk("resweep_len", 32'(cnt), 32'd2048);
        readEnable = 1'b1; readAddr = 11'h030;
        tick();
        readEnable = 1'b0;
        chk("resweep_data", readData, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
